fft_agu: RTL and testbench

- Address-generation and sequencing controller for the in-place radix-2 DIT FFT engine.
- Sits directly upstream of the twiddle ROM: drives its read enable and read address, and in the same cycle issues the data-RAM read address pair (a, b).
- Delays the read addresses to produce write-back addresses aligned with the butterfly output.
- Sequences all log2(N) stages, using ping-pong data banks, and inserts drain gaps between stages.

---
 rtl/fft_agu_if.sv | 40 ++++
 rtl/fft_agu.sv | 212 +++++++++++++++++++++
 tb/tb_fft_agu.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/fft_agu_if.sv
// Bus bundle between the FFT address generator and the RAM/ROM/butterfly side.
// master: the AGU; slave: the datapath that consumes its strobes and addresses.
interface fft_agu_if #(
    parameter int N = 16
);
    localparam int AW = $clog2(N);
    localparam int SW = $clog2($clog2(N)) + 1;

    logic          i_start;
    logic          o_busy;
    logic          o_done;
    logic [SW-1:0] o_stage;
    logic          o_rd_en;
    logic [AW-1:0] o_rd_addr_a;
    logic [AW-1:0] o_rd_addr_b;
    logic [AW-1:0] o_tw_addr;
    logic          o_rd_bank;
    logic          o_wr_en;
    logic [AW-1:0] o_wr_addr_a;
    logic [AW-1:0] o_wr_addr_b;
    logic          o_wr_bank;

    modport master (
        input  i_start,
        output o_busy, o_done, o_stage,
        output o_rd_en, o_rd_addr_a, o_rd_addr_b,
        output o_tw_addr, o_rd_bank,
        output o_wr_en, o_wr_addr_a, o_wr_addr_b,
        output o_wr_bank
    );

    modport slave (
        output i_start,
        input  o_busy, o_done, o_stage,
        input  o_rd_en, o_rd_addr_a, o_rd_addr_b,
        input  o_tw_addr, o_rd_bank,
        input  o_wr_en, o_wr_addr_a, o_wr_addr_b,
        input  o_wr_bank
    );
endinterface

// File: rtl/fft_agu.sv
// Radix-2 DIT FFT address generator / stage sequencer with ping-pong banks.
// Define FFT_AGU_BITREV_EN to bit-reverse stage-0 read addresses.
module fft_agu #(
    parameter int N      = 16,
    parameter int BF_LAT = 2
) (
    input  logic      clk,
    input  logic      i_rst,
    fft_agu_if.master bus
);
    localparam int AW  = $clog2(N);
    localparam int S   = AW;
    localparam int SW  = $clog2(S) + 1;
    localparam int KW  = AW - 1;
    localparam int LAT = 1 + BF_LAT;
    localparam int CW  = $clog2(LAT) + 1;

    localparam logic [KW-1:0] K_LAST = KW'(N / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(S - 1);
    localparam logic [CW-1:0] C_LAST = CW'(LAT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [AW-1:0] tw;
    } addr_t;

    state_t        state;
    logic [KW-1:0] k;
    logic [SW-1:0] s;
    logic [CW-1:0] cnt;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic          rd_bank;

    logic [AW-1:0] a_q, b_q, tw_q, ra_q, rb_q;

    logic [LAT-1:0] pe_en;
    logic [LAT-1:0] pe_bank;
    logic [AW-1:0]  pe_a [LAT];
    logic [AW-1:0]  pe_b [LAT];

    logic          load;
    logic [KW-1:0] nx_k;
    logic [SW-1:0] nx_s;
    addr_t         nx;

    function automatic addr_t calc(
        input logic [KW-1:0] kk,
        input logic [SW-1:0] ss
    );
        logic [AW-1:0] kx, half, pos, grp;
        addr_t r;
        kx   = AW'(kk);
        half = AW'(1) << ss;
        pos  = kx & (half - AW'(1));
        grp  = kx >> ss;
        r.a  = (grp << (ss + SW'(1))) | pos;
        r.b  = r.a + half;
        r.tw = pos << (SW'(S - 1) - ss);
        return r;
    endfunction

`ifdef FFT_AGU_BITREV_EN
    function automatic logic [AW-1:0] rev(input logic [AW-1:0] x);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) r[i] = x[AW-1-i];
        return r;
    endfunction
`endif

    // Address registers load the (k, s) that the next cycle will read.
    always_comb begin
        load = 1'b0;
        nx_k = '0;
        nx_s = '0;
        unique case (state)
            IDLE:    load = bus.i_start;
            RUN:     load = (k != K_LAST);
            DRAIN:   load = (cnt == C_LAST) && (s != S_LAST);
            default: load = 1'b0;
        endcase
        if (state == RUN) begin
            nx_k = k + KW'(1);
            nx_s = s;
        end else if (state == DRAIN) begin
            nx_s = s + SW'(1);
        end
        nx = calc(nx_k, nx_s);
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            k       <= '0;
            s       <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rd_en   <= 1'b0;
            rd_bank <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        state   <= RUN;
                        k       <= '0;
                        s       <= '0;
                        rd_bank <= 1'b0;
                        busy    <= 1'b1;
                        rd_en   <= 1'b1;
                    end
                end
                RUN: begin
                    if (k == K_LAST) begin
                        state <= DRAIN;
                        cnt   <= '0;
                        rd_en <= 1'b0;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                DRAIN: begin
                    if (cnt != C_LAST) begin
                        cnt <= cnt + CW'(1);
                    end else if (s == S_LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state   <= RUN;
                        s       <= s + SW'(1);
                        k       <= '0;
                        rd_bank <= ~rd_bank;
                        rd_en   <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    s       <= '0;
                    rd_bank <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            a_q  <= '0;
            b_q  <= '0;
            tw_q <= '0;
            ra_q <= '0;
            rb_q <= '0;
        end else if (load) begin
            a_q  <= nx.a;
            b_q  <= nx.b;
            tw_q <= nx.tw;
`ifdef FFT_AGU_BITREV_EN
            ra_q <= (nx_s == '0) ? rev(nx.a) : nx.a;
            rb_q <= (nx_s == '0) ? rev(nx.b) : nx.b;
`else
            ra_q <= nx.a;
            rb_q <= nx.b;
`endif
        end else if (state == DONE) begin
            a_q  <= '0;
            b_q  <= '0;
            tw_q <= '0;
            ra_q <= '0;
            rb_q <= '0;
        end
    end

    // Only live reads enter the write pipe, so it drains to all-zero.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            pe_en   <= '0;
            pe_bank <= '0;
            for (int i = 0; i < LAT; i++) begin
                pe_a[i] <= '0;
                pe_b[i] <= '0;
            end
        end else begin
            pe_en   <= {pe_en[LAT-2:0], rd_en};
            pe_bank <= {pe_bank[LAT-2:0], rd_en & ~rd_bank};
            pe_a[0] <= rd_en ? a_q : '0;
            pe_b[0] <= rd_en ? b_q : '0;
            for (int i = 1; i < LAT; i++) begin
                pe_a[i] <= pe_a[i-1];
                pe_b[i] <= pe_b[i-1];
            end
        end
    end

    assign bus.o_busy      = busy;
    assign bus.o_done      = done;
    assign bus.o_stage     = s;
    assign bus.o_rd_en     = rd_en;
    assign bus.o_rd_addr_a = ra_q;
    assign bus.o_rd_addr_b = rb_q;
    assign bus.o_tw_addr   = tw_q;
    assign bus.o_rd_bank   = rd_bank;
    assign bus.o_wr_en     = pe_en[LAT-1];
    assign bus.o_wr_addr_a = pe_a[LAT-1];
    assign bus.o_wr_addr_b = pe_b[LAT-1];
    assign bus.o_wr_bank   = pe_bank[LAT-1];
endmodule

// File: tb/tb_fft_agu.sv
// Bench for fft_agu (N=8, BF_LAT=2): cycle model plus literal schedule.
// Honors FFT_AGU_BITREV_EN for the stage-0 read expectations.
module tb_fft_agu;
    localparam int N      = 8;
    localparam int BF_LAT = 2;
    localparam int S      = 3;
    localparam int LAT    = 1 + BF_LAT;
    localparam int PER    = N / 2 + LAT;
    localparam int TOTAL  = S * PER + 1;
`ifdef FFT_AGU_BITREV_EN
    localparam bit BREV = 1'b1;
`else
    localparam bit BREV = 1'b0;
`endif

    logic clk = 1'b0;
    logic i_rst = 1'b1;
    int   nvec = 0;
    int   nbad = 0;
    int   mt = -1;

    fft_agu_if #(.N(N)) bus ();

    fft_agu #(.N(N), .BF_LAT(BF_LAT)) dut (
        .clk  (clk),
        .i_rst(i_rst),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit busy, done, rd_en, rd_bank;
        bit wr_en, wr_bank;
        int stage, ra, rb, tw, wa, wb;
    } exp_t;

    function automatic int brev(int x);
        int r = 0;
        for (int i = 0; i < S; i++) r = (r << 1) | ((x >> i) & 1);
        return r;
    endfunction

    function automatic int bf_a(int st, int k);
        int half = 1 << st;
        return (k / half) * 2 * half + (k % half);
    endfunction

    // Expected outputs at t cycles after the first RUN cycle; t<0 is idle.
    function automatic exp_t model(int t);
        exp_t e;
        int st, k, wt;
        e.busy = 0; e.done = 0; e.rd_en = 0; e.rd_bank = 0;
        e.wr_en = 0; e.wr_bank = 0;
        e.stage = 0; e.ra = 0; e.rb = 0; e.tw = 0; e.wa = 0; e.wb = 0;
        if (t < 0) return e;
        e.busy = 1;
        e.done = (t == TOTAL - 1);
        st = t / PER;
        k  = t % PER;
        e.stage = (st < S) ? st : S - 1;
        if (st < S && k < N / 2) begin
            e.rd_en   = 1;
            e.rd_bank = st[0];
            e.ra = bf_a(st, k);
            e.rb = e.ra + (1 << st);
            e.tw = (k % (1 << st)) * (N / (2 << st));
            if (BREV && st == 0) begin
                e.ra = brev(e.ra);
                e.rb = brev(e.rb);
            end
        end
        wt = t - LAT;
        if (wt >= 0 && wt / PER < S && wt % PER < N / 2) begin
            e.wr_en   = 1;
            e.wr_bank = !wt[0] ^ ((wt / PER) % 2 == 1) ? 1'b1 : 1'b0;
            e.wr_bank = ((wt / PER) % 2 == 0);
            e.wa = bf_a(wt / PER, wt % PER);
            e.wb = e.wa + (1 << (wt / PER));
        end
        return e;
    endfunction

    task automatic chk(string nm, logic [31:0] act, int expv);
        nvec++;
        if (act !== 32'(expv)) begin
            nbad++;
            $display("FAIL %s @%0t: got %0d, want %0d",
                     nm, $time, act, expv);
        end
    endtask

    always @(posedge clk or posedge i_rst) begin
        if (i_rst) mt <= -1;
        else if (mt < 0) mt <= bus.i_start ? 0 : -1;
        else if (mt == TOTAL - 1) mt <= -1;
        else mt <= mt + 1;
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        e = model(i_rst ? -1 : mt);
        chk("busy",  32'(bus.o_busy),  int'(e.busy));
        chk("done",  32'(bus.o_done),  int'(e.done));
        chk("stage", 32'(bus.o_stage), e.stage);
        chk("rd_en", 32'(bus.o_rd_en), int'(e.rd_en));
        chk("wr_en", 32'(bus.o_wr_en), int'(e.wr_en));
        if (e.rd_en || !e.busy) begin
            chk("rd_a",    32'(bus.o_rd_addr_a), e.ra);
            chk("rd_b",    32'(bus.o_rd_addr_b), e.rb);
            chk("tw",      32'(bus.o_tw_addr),   e.tw);
            chk("rd_bank", 32'(bus.o_rd_bank),   int'(e.rd_bank));
        end
        if (e.wr_en || !e.busy) begin
            chk("wr_a",    32'(bus.o_wr_addr_a), e.wa);
            chk("wr_b",    32'(bus.o_wr_addr_b), e.wb);
            chk("wr_bank", 32'(bus.o_wr_bank),   int'(e.wr_bank));
        end
    end

    int lit_c [12] = '{0, 1, 2, 3, 7, 8, 9, 10, 14, 15, 16, 17};
    int lit_a [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int lit_b [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int lit_t [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    int lit_k [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
`ifdef FFT_AGU_BITREV_EN
    int lit_ra [12] = '{0, 2, 1, 3, 0, 1, 4, 5, 0, 1, 2, 3};
    int lit_rb [12] = '{4, 6, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
`else
    int lit_ra [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int lit_rb [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
`endif

    task automatic lit_check(int c);
        chk("lit_done", 32'(bus.o_done), (c == 21) ? 1 : 0);
        for (int i = 0; i < 12; i++) begin
            if (lit_c[i] == c) begin
                chk("lit_rd_en", 32'(bus.o_rd_en),     1);
                chk("lit_rd_a",  32'(bus.o_rd_addr_a), lit_ra[i]);
                chk("lit_rd_b",  32'(bus.o_rd_addr_b), lit_rb[i]);
                chk("lit_tw",    32'(bus.o_tw_addr),   lit_t[i]);
                chk("lit_rbank", 32'(bus.o_rd_bank),   lit_k[i]);
            end
            if (lit_c[i] + 3 == c) begin
                chk("lit_wr_en", 32'(bus.o_wr_en),     1);
                chk("lit_wr_a",  32'(bus.o_wr_addr_a), lit_a[i]);
                chk("lit_wr_b",  32'(bus.o_wr_addr_b), lit_b[i]);
                chk("lit_wbank", 32'(bus.o_wr_bank),   1 - lit_k[i]);
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 bus.i_start = 1'b1;
        @(posedge clk);
        #1 bus.i_start = 1'b0;
    endtask

    task automatic full_run();
        pulse_start();
        for (int c = 0; c < TOTAL; c++) begin
            @(negedge clk);
            lit_check(c);
        end
    endtask

    initial begin
        int ndone;
        bus.i_start = 1'b0;
        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        repeat (10) @(negedge clk);

        full_run();
        repeat (4) @(negedge clk);

        // Second run: stray start mid-run, then async abort.
        pulse_start();
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            lit_check(c);
            bus.i_start = (c == 5);
        end
        @(posedge clk);
        #1 i_rst = 1'b1;
        #1;
        chk("arst_busy",  32'(bus.o_busy),      0);
        chk("arst_rd_en", 32'(bus.o_rd_en),     0);
        chk("arst_wr_en", 32'(bus.o_wr_en),     0);
        chk("arst_stage", 32'(bus.o_stage),     0);
        chk("arst_rbank", 32'(bus.o_rd_bank),   0);
        chk("arst_rd_a",  32'(bus.o_rd_addr_a), 0);
        chk("arst_wr_a",  32'(bus.o_wr_addr_a), 0);
        @(negedge clk);
        @(negedge clk);
        i_rst = 1'b0;
        ndone = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.o_done === 1'b1) ndone++;
        end
        chk("no_done_after_abort", 32'(ndone), 0);

        full_run();
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nbad);
        $finish;
    end
endmodule
